// File: rtl/pattern_pkg.sv
// Shared definitions for the serial pattern transmitter and the three-ones detector.
//   state_e    : transmitter FSM states (IDLE, SHIFT, GAP)
//   RUN_LEN    : number of consecutive ones that raises the detector output
//   RUN_CNT_W  : width of a counter that saturates at RUN_LEN
package pattern_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    GAP   = 2'b10
  } state_e;

  localparam int unsigned RUN_LEN   = 3;
  localparam int unsigned RUN_CNT_W = $clog2(RUN_LEN + 1);

endpackage

// File: rtl/run_predictor.sv
// Golden model of the three-ones detector: counts consecutive ones on X and
// raises EXPECT_Y once RUN_LEN ones have been sampled.
//   CLK      : clock, posedge
//   nRST     : synchronous reset, active-high
//   X        : serial bit stream (registered upstream)
//   EXPECT_Y : registered predicted detector output
module run_predictor
  import pattern_pkg::*;
(
  input  logic CLK,
  input  logic nRST,
  input  logic X,
  output logic EXPECT_Y
);

  logic [RUN_CNT_W-1:0] ones_cnt_q;
  logic [RUN_CNT_W-1:0] ones_cnt_d;
  logic                 y_q;

  // Saturating run counter; any zero restarts the run.
  always_comb begin
    ones_cnt_d = '0;
    if (X) begin
      if (ones_cnt_q == RUN_CNT_W'(RUN_LEN)) begin
        ones_cnt_d = ones_cnt_q;
      end else begin
        ones_cnt_d = ones_cnt_q + RUN_CNT_W'(1);
      end
    end
  end

  // y_q always equals (ones_cnt_q == RUN_LEN) but comes straight from a flop.
  always_ff @(posedge CLK) begin
    if (nRST) begin
      ones_cnt_q <= '0;
      y_q        <= 1'b0;
    end else begin
      ones_cnt_q <= ones_cnt_d;
      y_q        <= (ones_cnt_d == RUN_CNT_W'(RUN_LEN));
    end
  end

  assign EXPECT_Y = y_q;

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: accepts a frame over valid/ready, shifts it out
// MSB-first on X, follows it with GAP_CYCLES zero guard bits and predicts the
// three-ones detector output on EXPECT_Y.
//   CLK, nRST   : clock (posedge) and synchronous active-high reset
//   LOAD_VALID  : producer offers a frame
//   LOAD_READY  : combinational; high in IDLE while reset is released
//   LOAD_DATA   : frame bits, bit LOAD_LEN-1 is sent first
//   LOAD_LEN    : bits to send, 0 or >WIDTH means WIDTH
//   X, X_VALID  : serial data and frame-data qualifier
//   BUSY, DONE  : frame in progress / one-cycle end-of-frame pulse
//   EXPECT_Y    : predicted detector output
module serial_pattern_tx
  import pattern_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned LEN_W      = $clog2(WIDTH) + 1,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             LOAD_VALID,
  output logic             LOAD_READY,
  input  logic [WIDTH-1:0] LOAD_DATA,
  input  logic [LEN_W-1:0] LOAD_LEN,
  output logic             X,
  output logic             X_VALID,
  output logic             BUSY,
  output logic             DONE,
  output logic             EXPECT_Y
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [LEN_W-1:0] bit_cnt_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic             x_valid_q;
  logic             busy_q;
  logic             done_q;

  logic [LEN_W-1:0] len_eff_c;
  logic [LEN_W-1:0] shamt_c;
  logic [WIDTH-1:0] load_aligned_c;
  logic             accept_c;

  // Clamp the length and left-align the frame so its first bit lands in the MSB.
  always_comb begin
    len_eff_c = LOAD_LEN;
    if ((LOAD_LEN == '0) || (LOAD_LEN > LEN_W'(WIDTH))) begin
      len_eff_c = LEN_W'(WIDTH);
    end
    shamt_c        = LEN_W'(WIDTH) - len_eff_c;
    load_aligned_c = LOAD_DATA << shamt_c;
  end

  assign LOAD_READY = (state_q == IDLE) && !nRST;
  assign accept_c   = LOAD_VALID && LOAD_READY;

  // Frame FSM with registered status outputs.
  always_ff @(posedge CLK) begin
    if (nRST) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      x_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            shreg_q   <= load_aligned_c;
            bit_cnt_q <= len_eff_c;
            state_q   <= SHIFT;
            x_valid_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        SHIFT: begin
          // Zero fill leaves the register clear once the frame is out, so X idles low.
          shreg_q   <= shreg_q << 1;
          bit_cnt_q <= bit_cnt_q - LEN_W'(1);
          if (bit_cnt_q == LEN_W'(1)) begin
            x_valid_q <= 1'b0;
            if (GAP_CYCLES > 0) begin
              state_q   <= GAP;
              gap_cnt_q <= GAP_W'(GAP_CYCLES);
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        GAP: begin
          gap_cnt_q <= gap_cnt_q - GAP_W'(1);
          if (gap_cnt_q == GAP_W'(1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          shreg_q   <= '0;
          x_valid_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign X       = shreg_q[WIDTH-1];
  assign X_VALID = x_valid_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;

  run_predictor u_run_predictor (
    .CLK      (CLK),
    .nRST     (nRST),
    .X        (X),
    .EXPECT_Y (EXPECT_Y)
  );

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: two instances (GAP_CYCLES = 2 and 0) share the
// stimulus; every cycle both are checked against a timeline reference model,
// plus a frame table and hand-written reset/abort/back-to-back sequences.
module tb_serial_pattern_tx;

  logic       CLK = 1'b0;
  logic       nRST = 1'b1;
  logic       LOAD_VALID = 1'b0;
  logic [7:0] LOAD_DATA = '0;
  logic [3:0] LOAD_LEN = '0;

  logic ready_a, x_a, xv_a, busy_a, done_a, y_a;
  logic ready_b, x_b, xv_b, busy_b, done_b, y_b;
  logic [5:0] vec_a, vec_b;

  assign vec_a = {ready_a, x_a, xv_a, busy_a, done_a, y_a};
  assign vec_b = {ready_b, x_b, xv_b, busy_b, done_b, y_b};

  serial_pattern_tx #(.WIDTH(8), .LEN_W(4), .GAP_CYCLES(2)) dut_a (
    .CLK(CLK), .nRST(nRST), .LOAD_VALID(LOAD_VALID), .LOAD_READY(ready_a),
    .LOAD_DATA(LOAD_DATA), .LOAD_LEN(LOAD_LEN), .X(x_a), .X_VALID(xv_a),
    .BUSY(busy_a), .DONE(done_a), .EXPECT_Y(y_a)
  );

  serial_pattern_tx #(.WIDTH(8), .LEN_W(4), .GAP_CYCLES(0)) dut_b (
    .CLK(CLK), .nRST(nRST), .LOAD_VALID(LOAD_VALID), .LOAD_READY(ready_b),
    .LOAD_DATA(LOAD_DATA), .LOAD_LEN(LOAD_LEN), .X(x_b), .X_VALID(xv_b),
    .BUSY(busy_b), .DONE(done_b), .EXPECT_Y(y_b)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: a frame is described by its first-bit cycle, length and data.
  bit         m_act[2]  = '{0, 0};
  int         m_t0[2]   = '{0, 0};
  int         m_len[2]  = '{0, 0};
  logic [7:0] m_data[2] = '{8'h00, 8'h00};
  int         m_run[2]  = '{0, 0};
  int         cyc = 0;

  // Per-test observation counters.
  logic [7:0] col_a, col_b;
  int nb_a, nb_b, ny_a, ny_b, dl_a, dl_b, hs_a, hs_b, nd_a, nd_b, rel;

  typedef struct {
    logic [3:0] len;
    logic [7:0] data;
    logic [7:0] exp_bits;
    int         exp_n;
    int         exp_y;
  } vec_t;

  vec_t tbl[6];

  function automatic int gap_of(int idx);
    return (idx == 0) ? 2 : 0;
  endfunction

  // Expected {ready, x, x_valid, busy, done, expect_y} for the current cycle.
  function automatic logic [5:0] model_out(int idx);
    int o;
    int g;
    logic x, xv, busy, done, idle;
    g = gap_of(idx);
    x = 1'b0; xv = 1'b0; busy = 1'b0; done = 1'b0; idle = 1'b1;
    if (m_act[idx]) begin
      o = cyc - m_t0[idx];
      if (o < m_len[idx]) begin
        x = m_data[idx][m_len[idx] - 1 - o];
        xv = 1'b1; busy = 1'b1; idle = 1'b0;
      end else if (o < m_len[idx] + g) begin
        busy = 1'b1; idle = 1'b0;
      end else if (o == m_len[idx] + g) begin
        done = 1'b1;
      end
    end
    return {idle && !nRST, x, xv, busy, done, (m_run[idx] >= 3)};
  endfunction

  task automatic model_edge(input bit rst, input bit v, input logic [7:0] d, input logic [3:0] l);
    logic [5:0] e[2];
    for (int i = 0; i < 2; i++) e[i] = model_out(i);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_act[i] = 1'b0;
        m_run[i] = 0;
      end else begin
        m_run[i] = e[i][4] ? m_run[i] + 1 : 0;
        if (e[i][5] && v) begin
          m_act[i]  = 1'b1;
          m_t0[i]   = cyc;
          m_len[i]  = (l == 4'd0 || l > 4'd8) ? 8 : int'(l);
          m_data[i] = d;
        end
      end
    end
  endtask

  task automatic cmp_vec(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%b want=%b (rdy,x,xv,busy,done,y)", name, cyc, act, exp);
    end
  endtask

  task automatic cmp_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic clr();
    col_a = '0; col_b = '0;
    nb_a = 0; nb_b = 0; ny_a = 0; ny_b = 0; dl_a = -1; dl_b = -1;
    hs_a = 0; hs_b = 0; nd_a = 0; nd_b = 0; rel = 0;
  endtask

  // One clock cycle: drive, check at the falling edge, then advance the model.
  task automatic step(input bit rst, input bit v, input logic [7:0] d, input logic [3:0] l);
    nRST = rst; LOAD_VALID = v; LOAD_DATA = d; LOAD_LEN = l;
    @(negedge CLK);
    cmp_vec("cyc_a", vec_a, model_out(0));
    cmp_vec("cyc_b", vec_b, model_out(1));
    if (xv_a) begin col_a = {col_a[6:0], x_a}; nb_a++; end
    if (xv_b) begin col_b = {col_b[6:0], x_b}; nb_b++; end
    if (y_a) ny_a++;
    if (y_b) ny_b++;
    if (done_a && dl_a < 0) dl_a = rel;
    if (done_b && dl_b < 0) dl_b = rel;
    if (ready_a && v) hs_a++;
    if (ready_b && v) hs_b++;
    if (done_a) nd_a++;
    if (done_b) nd_b++;
    rel++;
    @(posedge CLK);
    model_edge(rst, v, d, l);
    #1;
  endtask

  initial begin
    tbl[0] = '{4'd8,  8'b0111_0110, 8'b0111_0110, 8, 1};
    tbl[1] = '{4'd3,  8'b0000_0111, 8'h07,        3, 1};
    tbl[2] = '{4'd0,  8'hFF,        8'hFF,        8, 6};
    tbl[3] = '{4'd12, 8'hA5,        8'hA5,        8, 0};
    tbl[4] = '{4'd1,  8'h01,        8'h01,        1, 0};
    tbl[5] = '{4'd5,  8'b1110_1111, 8'h0F,        5, 2};

    nRST = 1'b1; LOAD_VALID = 1'b1; LOAD_DATA = 8'hFF; LOAD_LEN = 4'd8;
    @(posedge CLK);
    #1;

    // Reset hold with a frame on offer: nothing may start.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'hFF, 4'd8);
    cmp_int("rst_ready_a", int'(ready_a), 0);
    cmp_int("rst_ready_b", int'(ready_b), 0);
    cmp_int("rst_x_a", int'(x_a), 0);
    cmp_int("rst_busy_a", int'(busy_a), 0);
    step(1'b0, 1'b0, 8'h00, 4'd0);
    cmp_int("rst_noframe_a", int'(busy_a), 0);

    // Frame table.
    for (int i = 0; i < 6; i++) begin
      clr();
      step(1'b0, 1'b1, tbl[i].data, tbl[i].len);
      for (int j = 0; j < 14; j++) step(1'b0, 1'b0, 8'h00, 4'd0);
      cmp_int($sformatf("tbl%0d_bits_a", i), int'(col_a), int'(tbl[i].exp_bits));
      cmp_int($sformatf("tbl%0d_bits_b", i), int'(col_b), int'(tbl[i].exp_bits));
      cmp_int($sformatf("tbl%0d_nbits_a", i), nb_a, tbl[i].exp_n);
      cmp_int($sformatf("tbl%0d_nbits_b", i), nb_b, tbl[i].exp_n);
      cmp_int($sformatf("tbl%0d_ycnt_a", i), ny_a, tbl[i].exp_y);
      cmp_int($sformatf("tbl%0d_ycnt_b", i), ny_b, tbl[i].exp_y);
      cmp_int($sformatf("tbl%0d_done_a", i), dl_a, 1 + tbl[i].exp_n + 2);
      cmp_int($sformatf("tbl%0d_done_b", i), dl_b, 1 + tbl[i].exp_n);
    end

    // Abort during bit 4 of an all-ones frame.
    step(1'b0, 1'b1, 8'hFF, 4'd8);
    for (int j = 0; j < 4; j++) step(1'b0, 1'b0, 8'h00, 4'd0);
    step(1'b1, 1'b0, 8'h00, 4'd0);
    cmp_int("abort_x_a", int'(x_a), 0);
    cmp_int("abort_busy_a", int'(busy_a), 0);
    cmp_int("abort_y_a", int'(y_a), 0);
    cmp_int("abort_busy_b", int'(busy_b), 0);
    cmp_int("abort_y_b", int'(y_b), 0);
    nRST = 1'b0;
    #1;
    cmp_int("abort_ready_a", int'(ready_a), 1);
    clr();
    for (int j = 0; j < 12; j++) step(1'b0, 1'b0, 8'h00, 4'd0);
    cmp_int("abort_nodone_a", nd_a, 0);
    cmp_int("abort_nodone_b", nd_b, 0);

    // Back-to-back offers with LOAD_VALID held high.
    clr();
    for (int j = 0; j < 20; j++) step(1'b0, 1'b1, 8'hA6, 4'd4);
    cmp_int("b2b_accepts_b", hs_b, 4);
    cmp_int("b2b_dones_b", nd_b, 3);
    cmp_int("b2b_accepts_a", hs_a, 3);
    cmp_int("b2b_dones_a", nd_a, 2);
    for (int j = 0; j < 12; j++) step(1'b0, 1'b0, 8'h00, 4'd0);

    // Random traffic with occasional mid-frame resets.
    for (int j = 0; j < 400; j++) begin
      step($urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)),
           8'($urandom), 4'($urandom_range(0, 15)));
    end
    for (int j = 0; j < 12; j++) step(1'b0, 1'b0, 8'h00, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
